cpu_bus_cycle_tracker: RTL and testbench

//  Consumes the raw Z80 cpu_bus strobes (asynchronous to the system clock) and turns each bus cycle

---
 rtl/cpu_bus_cycle_tracker_pkg.sv | 47 ++++
 rtl/cpu_bus_cycle_tracker_if.sv | 16 +
 rtl/cpu_bus_cycle_tracker_sync_ff.sv | 24 ++
 rtl/cpu_bus_cycle_tracker.sv | 178 +++++++++++++++++
 tb/tb_cpu_bus_cycle_tracker.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_cycle_tracker_pkg.sv
// Shared types for the Z80 bus cycle tracker: decoded cycle kinds, FSM states,
// synchronised strobe bundle and the cycle decode priority function.
package cpu_bus_cycle_tracker_pkg;

    typedef enum logic [2:0] {
        CYC_IDLE,
        CYC_IO_RD,
        CYC_IO_WR,
        CYC_MEM_RD,
        CYC_MEM_WR,
        CYC_RFSH,
        CYC_INTACK
    } cycle_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RELEASE
    } state_t;

    localparam int unsigned SYNC_W = 6;

    typedef struct packed {
        logic wr;
        logic rd;
        logic rfsh;
        logic m1;
        logic mreq;
        logic iorq;
    } strobes_t;

    // Priority: intack > io > refresh > memory; rd wins over wr when both are set.
    function automatic cycle_t decode_cycle(input strobes_t s);
        cycle_t res;
        res = CYC_IDLE;
        if (s.m1 && s.iorq)
            res = CYC_INTACK;
        else if (s.iorq && !s.m1 && (s.rd || s.wr))
            res = s.rd ? CYC_IO_RD : CYC_IO_WR;
        else if (s.mreq && s.rfsh)
            res = CYC_RFSH;
        else if (s.mreq && !s.rfsh && (s.rd || s.wr))
            res = s.rd ? CYC_MEM_RD : CYC_MEM_WR;
        return res;
    endfunction

endpackage

// File: rtl/cpu_bus_cycle_tracker_if.sv
// Z80 bus as seen by the tracker: address, data, active-high strobes, and the
// ioreq flag driven back by the tracker for the length of an IO cycle.
interface cpu_bus_cycle_tracker_if;
    logic [15:0] a;
    logic [7:0]  d;
    logic        iorq;
    logic        mreq;
    logic        m1;
    logic        rfsh;
    logic        rd;
    logic        wr;
    logic        ioreq;

    modport master (output a, d, iorq, mreq, m1, rfsh, rd, wr, input ioreq);
    modport slave  (input a, d, iorq, mreq, m1, rfsh, rd, wr, output ioreq);
endinterface

// File: rtl/cpu_bus_cycle_tracker_sync_ff.sv
// Multi-bit flop-chain synchroniser for the asynchronous bus strobes.
// All stages are cleared by the synchronous reset.
module sync_ff #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk) begin
        if (rst)
            r_stage <= '0;
        else
            r_stage <= {r_stage[STAGES-2:0], i_d};
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/cpu_bus_cycle_tracker.sv
// Turns raw Z80 bus cycles into single-clock events and latches IO address/data.
// Define CPU_BUS_INTACK_EN to enable interrupt-acknowledge detection.
module cpu_bus_cycle_tracker
    import cpu_bus_cycle_tracker_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REARM_CLKS  = 1
) (
    input  logic                          clk28,
    input  logic                          rst,
    cpu_bus_cycle_tracker_if.slave        bus,
    output cycle_t                        cycle,
    output logic                          io_rd_stb,
    output logic                          io_wr_stb,
    output logic                          mem_rd_stb,
    output logic                          mem_wr_stb,
    output logic                          rfsh_stb,
    output logic                          intack_stb,
    output logic [15:0]                   io_a,
    output logic [7:0]                    io_d
);

`ifdef CPU_BUS_INTACK_EN
    localparam bit INTACK_EN = 1'b1;
`else
    localparam bit INTACK_EN = 1'b0;
`endif

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] REARM_LOAD = CNT_W'(REARM_CLKS - 1);
    // After reset the synchroniser is empty, so an in-flight cycle only becomes
    // visible SYNC_STAGES clocks later; the first re-arm window covers that gap.
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(REARM_CLKS + SYNC_STAGES - 1);

    logic [SYNC_W-1:0] w_sync_raw;
    strobes_t          w_sync;
    cycle_t            w_dec;
    logic              w_any;
    logic              w_busy;
    logic              w_rearm_done;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_rearm_cnt;
    logic [CNT_W-1:0]  w_rearm_cnt_nxt;

    cycle_t            r_stb;
    cycle_t            w_stb_nxt;
    cycle_t            r_cycle;
    cycle_t            w_cycle_nxt;
    logic [15:0]       r_io_a;
    logic [15:0]       w_io_a_nxt;
    logic [7:0]        r_io_d;
    logic [7:0]        w_io_d_nxt;
    logic              r_ioreq;
    logic              w_ioreq_nxt;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (SYNC_W)
    ) u_sync (
        .clk (clk28),
        .rst (rst),
        .i_d ({bus.wr, bus.rd, bus.rfsh, bus.m1, bus.mreq, bus.iorq}),
        .o_q (w_sync_raw)
    );

    assign w_sync       = strobes_t'(w_sync_raw);
    assign w_dec        = decode_cycle(w_sync);
    assign w_any        = |w_sync_raw;
    assign w_busy       = w_sync.iorq | w_sync.mreq | w_sync.rd | w_sync.wr;
    assign w_rearm_done = (r_state == ST_RELEASE) && !w_any && (r_rearm_cnt == '0);

    always_ff @(posedge clk28) begin
        if (rst) begin
            r_state     <= ST_RELEASE;
            r_rearm_cnt <= RST_LOAD;
        end else begin
            r_state     <= w_state_nxt;
            r_rearm_cnt <= w_rearm_cnt_nxt;
        end
    end

    // An ignored intack still moves to ACTIVE so its tail cannot start a new cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_rearm_cnt_nxt = r_rearm_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_dec != CYC_IDLE)
                    w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!w_busy) begin
                    w_state_nxt     = ST_RELEASE;
                    w_rearm_cnt_nxt = REARM_LOAD;
                end
            end
            ST_RELEASE: begin
                if (w_any)
                    w_rearm_cnt_nxt = REARM_LOAD;
                else if (r_rearm_cnt == '0)
                    w_state_nxt = ST_IDLE;
                else
                    w_rearm_cnt_nxt = r_rearm_cnt - CNT_W'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_stb_nxt   = CYC_IDLE;
        w_cycle_nxt = r_cycle;
        w_io_a_nxt  = r_io_a;
        w_io_d_nxt  = r_io_d;
        w_ioreq_nxt = r_ioreq;
        case (r_state)
            ST_IDLE: begin
                if (w_dec == CYC_INTACK) begin
                    if (INTACK_EN) begin
                        w_stb_nxt   = CYC_INTACK;
                        w_cycle_nxt = CYC_INTACK;
                    end
                end else if (w_dec != CYC_IDLE) begin
                    w_stb_nxt   = w_dec;
                    w_cycle_nxt = w_dec;
                    if (w_dec == CYC_IO_RD || w_dec == CYC_IO_WR) begin
                        w_io_a_nxt  = bus.a;
                        w_ioreq_nxt = 1'b1;
                    end
                    if (w_dec == CYC_IO_WR)
                        w_io_d_nxt = bus.d;
                end
            end
            ST_ACTIVE: begin
                if (!w_busy)
                    w_ioreq_nxt = 1'b0;
            end
            ST_RELEASE: begin
                if (w_rearm_done)
                    w_cycle_nxt = CYC_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            r_stb   <= CYC_IDLE;
            r_cycle <= CYC_IDLE;
            r_io_a  <= '0;
            r_io_d  <= '0;
            r_ioreq <= 1'b0;
        end else begin
            r_stb   <= w_stb_nxt;
            r_cycle <= w_cycle_nxt;
            r_io_a  <= w_io_a_nxt;
            r_io_d  <= w_io_d_nxt;
            r_ioreq <= w_ioreq_nxt;
        end
    end

    assign cycle      = r_cycle;
    assign io_a       = r_io_a;
    assign io_d       = r_io_d;
    assign bus.ioreq  = r_ioreq;
    assign io_rd_stb  = (r_stb == CYC_IO_RD);
    assign io_wr_stb  = (r_stb == CYC_IO_WR);
    assign mem_rd_stb = (r_stb == CYC_MEM_RD);
    assign mem_wr_stb = (r_stb == CYC_MEM_WR);
    assign rfsh_stb   = (r_stb == CYC_RFSH);
`ifdef CPU_BUS_INTACK_EN
    assign intack_stb = (r_stb == CYC_INTACK);
`else
    assign intack_stb = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_cycle_tracker.sv
// Self-checking bench for cpu_bus_cycle_tracker: default instance plus a
// REARM_CLKS=3 instance sharing the same pin stimulus.
module tb_cpu_bus_cycle_tracker;
    import cpu_bus_cycle_tracker_pkg::*;

    logic clk28 = 1'b0;
    logic rst;
    always #5 clk28 = ~clk28;

    cpu_bus_cycle_tracker_if bus ();
    cpu_bus_cycle_tracker_if bus3 ();

    cycle_t      cycle, cycle3;
    logic        io_rd_stb, io_wr_stb, mem_rd_stb, mem_wr_stb, rfsh_stb, intack_stb;
    logic        io_rd_stb3, io_wr_stb3, mem_rd_stb3, mem_wr_stb3, rfsh_stb3, intack_stb3;
    logic [15:0] io_a, io_a3;
    logic [7:0]  io_d, io_d3;

    cpu_bus_cycle_tracker dut (
        .clk28      (clk28),
        .rst        (rst),
        .bus        (bus),
        .cycle      (cycle),
        .io_rd_stb  (io_rd_stb),
        .io_wr_stb  (io_wr_stb),
        .mem_rd_stb (mem_rd_stb),
        .mem_wr_stb (mem_wr_stb),
        .rfsh_stb   (rfsh_stb),
        .intack_stb (intack_stb),
        .io_a       (io_a),
        .io_d       (io_d)
    );

    cpu_bus_cycle_tracker #(
        .SYNC_STAGES (2),
        .REARM_CLKS  (3)
    ) dut3 (
        .clk28      (clk28),
        .rst        (rst),
        .bus        (bus3),
        .cycle      (cycle3),
        .io_rd_stb  (io_rd_stb3),
        .io_wr_stb  (io_wr_stb3),
        .mem_rd_stb (mem_rd_stb3),
        .mem_wr_stb (mem_wr_stb3),
        .rfsh_stb   (rfsh_stb3),
        .intack_stb (intack_stb3),
        .io_a       (io_a3),
        .io_d       (io_d3)
    );

`ifdef CPU_BUS_INTACK_EN
    localparam cycle_t EXP_INTACK = CYC_INTACK;
`else
    localparam cycle_t EXP_INTACK = CYC_IDLE;
`endif

    // pin vectors: {wr, rd, rfsh, m1, mreq, iorq}
    localparam logic [5:0] P_IOWR   = 6'b100001;
    localparam logic [5:0] P_IORD   = 6'b010001;
    localparam logic [5:0] P_IOBOTH = 6'b110001;
    localparam logic [5:0] P_IOONLY = 6'b000001;
    localparam logic [5:0] P_FETCH  = 6'b010110;
    localparam logic [5:0] P_RFSH   = 6'b001010;
    localparam logic [5:0] P_MEMRD  = 6'b010010;
    localparam logic [5:0] P_MEMWR  = 6'b100010;
    localparam logic [5:0] P_INTACK = 6'b000101;

    typedef struct {
        cycle_t      cyc;
        logic [15:0] a;
        logic [7:0]  d;
        logic        ioreq;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic [5:0]  pins;
        int          hold;
        int          gap;
        cycle_t      exp_cyc;
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        logic        exp_ioreq;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    int   n_stb3 = 0;
    int   base3;
    logic seen;

    logic [5:0] w_obs, w_obs3;
    assign w_obs  = {intack_stb, rfsh_stb, mem_wr_stb, mem_rd_stb, io_wr_stb, io_rd_stb};
    assign w_obs3 = {intack_stb3, rfsh_stb3, mem_wr_stb3, mem_rd_stb3, io_wr_stb3, io_rd_stb3};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [5:0] stb_vec_of(input cycle_t c);
        logic [5:0] v;
        case (c)
            CYC_IO_RD:  v = 6'b000001;
            CYC_IO_WR:  v = 6'b000010;
            CYC_MEM_RD: v = 6'b000100;
            CYC_MEM_WR: v = 6'b001000;
            CYC_RFSH:   v = 6'b010000;
            CYC_INTACK: v = 6'b100000;
            default:    v = 6'b000000;
        endcase
        return v;
    endfunction

    always @(negedge clk28) begin
        if (w_obs != 6'b0) begin
            check("stb_onehot", 32'($onehot(w_obs)), 32'd1);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_stb actual=%b required=000000", w_obs);
            end else begin
                mon_e = sb_q.pop_front();
                check("stb_kind", 32'(w_obs), 32'(stb_vec_of(mon_e.cyc)));
                check("stb_cycle", 32'(cycle), 32'(mon_e.cyc));
                check("stb_io_a", 32'(io_a), 32'(mon_e.a));
                check("stb_io_d", 32'(io_d), 32'(mon_e.d));
                check("stb_ioreq", 32'(bus.ioreq), 32'(mon_e.ioreq));
            end
        end
        if (w_obs3 != 6'b0) begin
            n_stb3++;
            check("stb3_onehot", 32'($onehot(w_obs3)), 32'd1);
        end
    end

    task automatic drive_pins(input logic [15:0] a, input logic [7:0] d, input logic [5:0] p);
        bus.a = a;    bus.d = d;
        bus3.a = a;   bus3.d = d;
        {bus.wr, bus.rd, bus.rfsh, bus.m1, bus.mreq, bus.iorq}       = p;
        {bus3.wr, bus3.rd, bus3.rfsh, bus3.m1, bus3.mreq, bus3.iorq} = p;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk28);
        #2;
    endtask

    task automatic push_exp(input cycle_t c, input logic [15:0] a, input logic [7:0] d, input logic rq);
        exp_t e;
        e.cyc = c; e.a = a; e.d = d; e.ioreq = rq;
        sb_q.push_back(e);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        drive_pins(a, d, P_IOWR);
        tick(5);
        drive_pins(a, d, 6'b0);
    endtask

    initial begin
        vecs[0] = '{16'h00FE, 8'hAA, P_IORD,   5, 6, CYC_IO_RD,  16'h00FE, 8'h17, 1'b1};
        vecs[1] = '{16'h0038, 8'h00, P_FETCH,  4, 2, CYC_MEM_RD, 16'h00FE, 8'h17, 1'b0};
        vecs[2] = '{16'h0012, 8'h00, P_RFSH,   4, 6, CYC_RFSH,   16'h00FE, 8'h17, 1'b0};
        vecs[3] = '{16'h4000, 8'h55, P_MEMWR,  5, 6, CYC_MEM_WR, 16'h00FE, 8'h17, 1'b0};
        vecs[4] = '{16'h00FF, 8'h00, P_INTACK, 6, 6, EXP_INTACK, 16'h00FE, 8'h17, 1'b0};
        vecs[5] = '{16'h1234, 8'h99, P_IOBOTH, 5, 6, CYC_IO_RD,  16'h1234, 8'h17, 1'b1};
        vecs[6] = '{16'hBEEF, 8'h00, P_IOONLY, 5, 6, CYC_IDLE,   16'h1234, 8'h17, 1'b0};
        vecs[7] = '{16'h00FE, 8'h3C, P_IOWR,   5, 6, CYC_IO_WR,  16'h00FE, 8'h3C, 1'b1};
        vecs[8] = '{16'h8000, 8'h00, P_MEMRD,  5, 6, CYC_MEM_RD, 16'h00FE, 8'h3C, 1'b0};

        rst = 1'b1;
        drive_pins(16'h0000, 8'h00, 6'b0);
        tick(3);
        check("rst_cycle", 32'(cycle), 32'(CYC_IDLE));
        check("rst_io_a", 32'(io_a), 32'h0);
        check("rst_io_d", 32'(io_d), 32'h0);
        check("rst_ioreq", 32'(bus.ioreq), 32'h0);
        check("rst_stb", 32'(w_obs), 32'h0);
        rst = 1'b0;
        tick(6);

        // IO write: exact strobe and ioreq timing
        push_exp(CYC_IO_WR, 16'h7FFD, 8'h17, 1'b1);
        drive_pins(16'h7FFD, 8'h17, P_IOWR);
        tick(2);
        check("t1_clk2_stb", 32'(io_wr_stb), 32'h0);
        check("t1_clk2_ioreq", 32'(bus.ioreq), 32'h0);
        tick(1);
        check("t1_clk3_stb", 32'(io_wr_stb), 32'h1);
        check("t1_clk3_ioreq", 32'(bus.ioreq), 32'h1);
        tick(1);
        check("t1_clk4_stb", 32'(io_wr_stb), 32'h0);
        check("t1_clk4_ioreq", 32'(bus.ioreq), 32'h1);
        check("t1_clk4_io_a", 32'(io_a), 32'h7FFD);
        check("t1_clk4_io_d", 32'(io_d), 32'h17);
        tick(4);
        drive_pins(16'h7FFD, 8'h17, 6'b0);
        tick(2);
        check("t1_rel2_ioreq", 32'(bus.ioreq), 32'h1);
        tick(1);
        check("t1_rel3_ioreq", 32'(bus.ioreq), 32'h0);
        tick(6);

        for (int i = 0; i < 9; i++) begin
            seen = 1'b0;
            if (vecs[i].exp_cyc != CYC_IDLE)
                push_exp(vecs[i].exp_cyc, vecs[i].exp_a, vecs[i].exp_d, vecs[i].exp_ioreq);
            drive_pins(vecs[i].a, vecs[i].d, vecs[i].pins);
            for (int k = 0; k < vecs[i].hold; k++) begin
                tick(1);
                seen = seen | bus.ioreq;
            end
            drive_pins(vecs[i].a, vecs[i].d, 6'b0);
            for (int k = 0; k < vecs[i].gap; k++) begin
                tick(1);
                seen = seen | bus.ioreq;
            end
            check($sformatf("vec%0d_ioreq_seen", i), 32'(seen), 32'(vecs[i].exp_ioreq));
            if (vecs[i].gap >= 6)
                check($sformatf("vec%0d_cycle_idle", i), 32'(cycle), 32'(CYC_IDLE));
        end

        // Reset in the middle of an IO write
        push_exp(CYC_IO_WR, 16'h1FFD, 8'h04, 1'b1);
        drive_pins(16'h1FFD, 8'h04, P_IOWR);
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_io_a", 32'(io_a), 32'h0);
        check("t5_io_d", 32'(io_d), 32'h0);
        check("t5_cycle", 32'(cycle), 32'(CYC_IDLE));
        check("t5_ioreq", 32'(bus.ioreq), 32'h0);
        check("t5_stb", 32'(w_obs), 32'h0);
        tick(2);
        drive_pins(16'h1FFD, 8'h04, 6'b0);
        tick(8);
        push_exp(CYC_IO_WR, 16'h0033, 8'h81, 1'b1);
        io_write(16'h0033, 8'h81);
        tick(10);

        // Back-to-back IO writes, 1 idle clock apart: second one is swallowed
        base3 = n_stb3;
        push_exp(CYC_IO_WR, 16'hA001, 8'h11, 1'b1);
        io_write(16'hA001, 8'h11);
        tick(1);
        io_write(16'hA002, 8'h22);
        tick(12);
        check("t6_rearm3_short_gap", 32'(n_stb3 - base3), 32'd1);
        check("t6_rearm3_io_a", 32'(io_a3), 32'hA001);

        // Same pair with a 6-clock gap: both detected
        base3 = n_stb3;
        push_exp(CYC_IO_WR, 16'hA003, 8'h33, 1'b1);
        push_exp(CYC_IO_WR, 16'hA004, 8'h44, 1'b1);
        io_write(16'hA003, 8'h33);
        tick(6);
        io_write(16'hA004, 8'h44);
        tick(12);
        check("t6_rearm3_long_gap", 32'(n_stb3 - base3), 32'd2);
        check("t6_rearm3_io_a2", 32'(io_a3), 32'hA004);
        check("t6_rearm3_io_d2", 32'(io_d3), 32'h44);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
